// File: rtl/wordcatch_pkg.sv
// Shared types and constants for the wordcatch serial character buffer.
// Optional terminator support is enabled by defining WORDCATCH_TERM_EN.
package wordcatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int ADDR_W = 6;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam int DEFAULT_DEPTH = 36;

endpackage

// File: rtl/cereal_rx.sv
// 8N1 serial receiver: synchronizer, start/data/stop sampling.
// Emits a one-cycle valid per good byte and a one-cycle frame_err pulse.
module cereal_rx
  import wordcatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);

  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bits;
  logic [7:0]    shift;
  logic          s1;
  logic          s2;
  logic          s3;

  // s1/s2 synchronize; s3 is the previous s2 for falling-edge detect
  always_ff @(posedge sysclk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bits      <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s3 && !s2) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            bits  <= '0;
            state <= s2 ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            shift <= {s2, shift[7:1]};
            bits  <= bits + 1'b1;
            if (bits == 3'd7) state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            state <= IDLE;
            if (s2) begin
              valid <= 1'b1;
              data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wordcatch.sv
// Serial character catcher: buffers received bytes, tracks errors.
// Define WORDCATCH_TERM_EN to add the sticky word_done CR terminator.
module wordcatch
  import wordcatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              rx,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] count,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic              frame_err,
`ifdef WORDCATCH_TERM_EN
  output logic              word_done,
`endif
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

  logic       rx_ferr;
  logic       take;
  logic       store;
  logic       drop;
  logic [7:0] mem [DEPTH];
`ifdef WORDCATCH_TERM_EN
  logic       hit;
`endif

  cereal_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .sysclk   (sysclk),
    .rst      (rst),
    .rx       (rx),
    .data     (byte_out),
    .valid    (byte_valid),
    .frame_err(rx_ferr)
  );

  // clr in the same cycle as a byte swallows that byte
  always_comb begin
    take  = byte_valid && !clr;
`ifdef WORDCATCH_TERM_EN
    hit   = take && !word_done && (byte_out == CHAR_CR);
    store = take && !word_done && (byte_out != CHAR_CR) && (count != FULL);
    drop  = take && !word_done && (byte_out != CHAR_CR) && (count == FULL);
`else
    store = take && (count != FULL);
    drop  = take && (count == FULL);
`endif
  end

  always_ff @(posedge sysclk) begin
    if (rst || clr) begin
      count     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef WORDCATCH_TERM_EN
      word_done <= 1'b0;
`endif
    end else begin
      if (store) count <= count + 1'b1;
      if (drop) overflow <= 1'b1;
      if (rx_ferr) frame_err <= 1'b1;
`ifdef WORDCATCH_TERM_EN
      if (hit) word_done <= 1'b1;
`endif
    end
  end

  always_ff @(posedge sysclk) begin
    if (store) mem[count] <= byte_out;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= (rd_addr < count) ? mem[rd_addr] : 8'h00;
    end
  end

endmodule

// File: doc/wordcatch.md
WORDCATCH -- requirements
Module: wordcatch

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, sysclk cycles per serial bit (9600 baud at 100 MHz); legal values 8 or more.
REQ-002 SHALL have parameter DEPTH, default 36, number of character slots in the buffer.
REQ-003 SHALL have port sysclk  input  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line: 8N1, idle high, LSB first.
REQ-006 SHALL have port clr  input  1  single-cycle clear of the buffer and error flags.
REQ-007 SHALL have port rd_addr  input  6  buffer read address.
REQ-008 SHALL have port rd_data  output  8  character at rd_addr; 0x00 if rd_addr >= count.
REQ-009 SHALL have port count  output  6  number of characters stored.
REQ-010 SHALL have port byte_valid  output  1  one-cycle pulse for each good byte received.
REQ-011 SHALL have port byte_out  output  8  last good byte; held until the next good byte.
REQ-012 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-013 SHALL have port overflow  output  1  sticky: byte dropped because the buffer was full.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer before any use; edge detection and sampling use the synchronized value only.
REQ-015 SHALL use receiver states IDLE, START, DATA, STOP; the bit timer counts 0..CLKS_PER_BIT-1.
REQ-016 IDLE: on a synchronized high-to-low transition, go to START and clear the timer.
REQ-017 START: at timer = CLKS_PER_BIT/2 (integer division) re-sample rx; if low, go to DATA, otherwise treat as a glitch and return to IDLE.
REQ-018 DATA: sample rx every CLKS_PER_BIT cycles after the mid-start point; shift LSB first; after the 8th sample go to STOP.
REQ-019 STOP: one CLKS_PER_BIT after the 8th data sample, sample rx.
- High: pulse byte_valid for one cycle and update byte_out in the same cycle.
- Low: set frame_err and discard the byte.
- Either way, return to IDLE on the next cycle so back-to-back frames are accepted.
REQ-020 On byte_valid with count < DEPTH: write the byte to slot count and increment count (6-bit, no wrap).
REQ-021 On byte_valid with count = DEPTH: drop the byte, set overflow, leave count unchanged.
REQ-022 clr: count, frame_err and overflow go to 0 on the next cycle; buffer contents are not erased.
- clr and byte_valid in the same cycle: clr wins and the byte is not stored.
- clr does not disturb a frame in progress.
REQ-023 rd_data SHALL be registered, one cycle after rd_addr; a write and a read of the same slot in the same cycle return the old data.

Reset
REQ-024 rst SHALL set, on the next edge:
- state to IDLE, timer 0, shift register 0;
- synchronizer flops to 1;
- count, byte_valid, byte_out, frame_err, overflow, rd_data to 0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no byte_valid pulse; buffer memory is not cleared.

Configuration
REQ-026 Macro WORDCATCH_TERM_EN, when defined, adds output word_done (1 bit, sticky).
- A good byte 0x0D is not stored and sets word_done.
- While word_done is set, further good bytes are dropped without setting overflow.
- clr and rst clear word_done.
- Without the macro: no word_done port, and 0x0D is stored like any other byte.

Structure
REQ-027 Package wordcatch_pkg SHALL hold the rx state enum, ADDR_W = 6, CHAR_CR = 8'h0D and DEFAULT_DEPTH = 36.
REQ-028 The serial receiver (REQ-014..REQ-019) SHALL be sub-module cereal_rx with ports sysclk, rst, rx, data, valid, frame_err.
- wordcatch holds only the buffer, counters and flags.

Verification (CLKS_PER_BIT = 16, DEPTH = 36)
REQ-029 Send 0x41 8N1 -> byte_valid one pulse, byte_out 0x41, count 1; rd_addr 0 gives rd_data 0x41 one cycle later.
REQ-030 Send 37 back-to-back bytes 0x00..0x24 with no idle gap -> count 36, slot 35 = 0x23, overflow 1, byte_valid 37 pulses.
REQ-031 rx low for 5 cycles, then high -> no state leaves IDLE past START, no byte_valid; then send 0x55 with stop bit driven low -> frame_err 1, count unchanged.
REQ-032 Assert clr in the same cycle as byte_valid for 0x7A -> count 0, frame_err 0, overflow 0, 0x7A not stored.
REQ-033 Assert rst at data bit 4 of 0xC3, then send 0x31 -> no pulse for 0xC3; 0x31 stored at slot 0.
REQ-034 With WORDCATCH_TERM_EN, send "HI", 0x0D, "X" -> count 2, word_done 1, overflow 0, slot 2 not written.
